simplez_core: RTL and testbench

- Parametrised, complete SIMPLEZ processor core: full 8-instruction ISA executed by a multicycle sequencer (I0/I1/O0/O1 plus HALT).
- Main memory and peripherals sit outside the core, on a synchronous single-port memory bus with 1-cycle read latency.
- Architectural state is exposed for monitoring (LEDs, testbench): accumulator, program counter, instruction register, stop flag.
- Replaces the fetch-only sequencer in the top-level design.

---
 rtl/simplez_core.sv | 118 +++++++++++
 tb/tb_simplez_core.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/simplez_core.sv
// SIMPLEZ processor core: 8-instruction accumulator machine, multicycle sequencer
// (I0/I1/O0/O1/HALT) on a single-port synchronous memory bus with 1-cycle read latency.
module simplez_core #(
   parameter int DATAW = 12,
   parameter int ADDRW = 9,
   parameter logic [ADDRW-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             run,
   output logic [ADDRW-1:0] mem_addr,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [DATAW-1:0] mem_wdata,
   input  logic [DATAW-1:0] mem_rdata,
   output logic [DATAW-1:0] ac,
   output logic [ADDRW-1:0] cp,
   output logic [DATAW-1:0] ri,
   output logic             stop
);

   typedef enum logic [2:0] {
      S_I0,
      S_I1,
      S_O0,
      S_O1,
      S_HALT
   } state_t;

   localparam logic [2:0] OP_ST   = 3'd0;
   localparam logic [2:0] OP_LD   = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_BR   = 3'd3;
   localparam logic [2:0] OP_BZ   = 3'd4;
   localparam logic [2:0] OP_CLR  = 3'd5;
   localparam logic [2:0] OP_DEC  = 3'd6;
   localparam logic [2:0] OP_HALT = 3'd7;

   state_t           state;
   logic [2:0]       fetch_op;
   logic [ADDRW-1:0] fetch_cd;
   logic [2:0]       ri_op;
   logic [ADDRW-1:0] ri_cd;

   // Decode straight from the bus during I1 so single-phase instructions finish there.
   assign fetch_op  = mem_rdata[DATAW-1 -: 3];
   assign fetch_cd  = mem_rdata[ADDRW-1:0];
   assign ri_op     = ri[DATAW-1 -: 3];
   assign ri_cd     = ri[ADDRW-1:0];
   assign mem_wdata = ac;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_I0;
         cp    <= RESET_PC;
         ac    <= '0;
         ri    <= '0;
         stop  <= 1'b0;
      end else begin
         case (state)
            S_I0: state <= S_I1;
            S_I1: begin
               ri    <= mem_rdata;
               cp    <= cp + ADDRW'(1);
               state <= S_I0;
               case (fetch_op)
                  OP_CLR: ac <= '0;
                  OP_DEC: ac <= ac - DATAW'(1);
                  OP_BR:  cp <= fetch_cd;
                  OP_BZ:  if (ac == '0) cp <= fetch_cd;
                  OP_HALT: begin
                     state <= S_HALT;
                     stop  <= 1'b1;
                  end
                  default: state <= S_O0;
               endcase
            end
            S_O0: state <= (ri_op == OP_ST) ? S_I0 : S_O1;
            S_O1: begin
               if (ri_op == OP_LD) ac <= mem_rdata;
               else                ac <= ac + mem_rdata;
               state <= S_I0;
            end
            S_HALT: begin
               if (run) begin
                  state <= S_I0;
                  stop  <= 1'b0;
               end
            end
            default: state <= S_I0;
         endcase
      end
   end

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      mem_addr = cp;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      case (state)
         S_I0: mem_rd = 1'b1;
         S_O0: begin
            mem_addr = ri_cd;
            if (ri_op == OP_ST) mem_wr = 1'b1;
            else                mem_rd = 1'b1;
         end
         default: ;
      endcase
      // Strobes are masked while reset is held so an interrupted store never reaches memory.
      if (!rstn) begin
         mem_rd = 1'b0;
         mem_wr = 1'b0;
      end
   end

endmodule

// File: tb/tb_simplez_core.sv
// Directed bench for simplez_core: small programs run against a behavioural
// 512x12 synchronous memory, checking architectural state and bus strobes.
module tb_simplez_core;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        run = 1'b0;
   logic [8:0]  mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata;
   logic [11:0] ac;
   logic [8:0]  cp;
   logic [11:0] ri;
   logic        stop;

   logic [11:0] mem [512];
   int checks = 0;
   int failures = 0;

   simplez_core #(.DATAW(12), .ADDRW(9), .RESET_PC(9'd0)) dut (
      .clk(clk), .rstn(rstn), .run(run),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .ac(ac), .cp(cp), .ri(ri), .stop(stop)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 512; i++) mem[i] = 12'h000;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      run  = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic release_reset();
      rstn = 1'b1;
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Encodings: {op[2:0], cd[8:0]}
   function automatic logic [11:0] ins(input logic [2:0] op, input logic [8:0] cd);
      return {op, cd};
   endfunction

   int n;
   logic strobe_seen;

   initial begin
      // Reset state and first fetch
      clear_mem();
      mem[0]   = ins(3'd1, 9'd100);   // LD 100
      mem[1]   = ins(3'd2, 9'd101);   // ADD 101
      mem[2]   = ins(3'd0, 9'd102);   // ST 102
      mem[3]   = ins(3'd7, 9'd0);     // HALT
      mem[4]   = ins(3'd7, 9'd0);     // HALT
      mem[100] = 12'd5;
      mem[101] = 12'd7;
      do_reset();
      check("rst_ac", ac, 0);
      check("rst_cp", cp, 0);
      check("rst_ri", ri, 0);
      check("rst_stop", stop, 0);
      check("rst_rd", mem_rd, 0);
      check("rst_wr", mem_wr, 0);
      @(negedge clk);
      release_reset();
      check("first_rd", mem_rd, 1);
      check("first_addr", mem_addr, 0);

      // LD/ADD/ST/HALT program: 13 cycles to HALT
      cycles(12);
      check("prog_not_yet_stop", stop, 0);
      cycles(1);
      check("prog_stop", stop, 1);
      check("prog_ac", ac, 12);
      check("prog_cp", cp, 4);
      check("prog_ri", ri, 12'hE00);
      check("prog_mem102", mem[102], 12);

      // Idle in HALT: no strobes for 5 cycles
      strobe_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         strobe_seen = strobe_seen | mem_rd | mem_wr;
      end
      check("halt_no_strobe", strobe_seen, 0);
      check("halt_still_stop", stop, 1);

      // Restart with a one-cycle run pulse
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      check("run_stop_clear", stop, 0);
      check("run_rd", mem_rd, 1);
      check("run_addr", mem_addr, 4);
      cycles(2);
      check("run_halt_again", stop, 1);
      check("run_cp", cp, 5);

      // CLR; BZ taken, then DEC; BZ not taken
      clear_mem();
      mem[0]  = ins(3'd5, 9'd0);      // CLR
      mem[1]  = ins(3'd4, 9'd10);     // BZ 10
      mem[10] = ins(3'd6, 9'd0);      // DEC
      mem[11] = ins(3'd4, 9'd20);     // BZ 20
      mem[12] = ins(3'd7, 9'd0);      // HALT
      do_reset();
      release_reset();
      cycles(4);
      check("bz_taken_cp", cp, 10);
      check("bz_taken_ac", ac, 0);
      cycles(4);
      check("bz_not_taken_ac", ac, 12'hFFF);
      check("bz_not_taken_cp", cp, 12);
      cycles(2);
      check("bz_halt_stop", stop, 1);
      check("bz_halt_cp", cp, 13);

      // ADD overflow and CP wrap
      clear_mem();
      mem[0]   = ins(3'd6, 9'd0);     // DEC -> FFF
      mem[1]   = ins(3'd2, 9'd100);   // ADD 100
      mem[2]   = ins(3'd3, 9'd511);   // BR 511
      mem[511] = ins(3'd7, 9'd0);     // HALT
      mem[100] = 12'd2;
      do_reset();
      release_reset();
      cycles(6);
      check("add_ovf_ac", ac, 12'h001);
      cycles(2);
      check("br_cp", cp, 511);
      cycles(2);
      check("wrap_stop", stop, 1);
      check("wrap_cp", cp, 0);

      // DEC loop from 3: 4 + 6 + 6 + 4 + 2 = 22 cycles
      clear_mem();
      mem[0]   = ins(3'd1, 9'd100);   // LD 100
      mem[1]   = ins(3'd6, 9'd0);     // DEC
      mem[2]   = ins(3'd4, 9'd4);     // BZ 4
      mem[3]   = ins(3'd3, 9'd1);     // BR 1
      mem[4]   = ins(3'd7, 9'd0);     // HALT
      mem[100] = 12'd3;
      do_reset();
      release_reset();
      n = 0;
      while (!stop && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("loop_cycles", n, 22);
      check("loop_ac", ac, 0);
      check("loop_cp", cp, 5);

      // Reset asserted during a store's O0
      clear_mem();
      mem[0]   = ins(3'd1, 9'd100);   // LD 100
      mem[1]   = ins(3'd0, 9'd102);   // ST 102
      mem[100] = 12'd9;
      mem[102] = 12'h055;
      do_reset();
      release_reset();
      cycles(6);
      check("st_o0_wr", mem_wr, 1);
      check("st_o0_addr", mem_addr, 102);
      rstn = 1'b0;
      #1;
      check("abort_wr", mem_wr, 0);
      check("abort_rd", mem_rd, 0);
      cycles(2);
      check("abort_mem102", mem[102], 12'h055);
      check("abort_ac", ac, 0);
      check("abort_cp", cp, 0);
      check("abort_ri", ri, 0);
      check("abort_stop", stop, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
